ieee80211_descrambler: RTL and testbench

Receive-side 802.11 descrambler: the inverse of the transmit scrambler (x^7 + x^4 + 1). It recovers the scrambler state from the first 7 bits of each frame (SERVICE field, transmitted as zeros before scrambling) and descrambles the rest of the frame. It sits in the RX chain after the Viterbi decoder, consumes WIDTH-bit decoded words on AXI-Stream, and emits descrambled words on AXI-Stream with one register stage.

---
 rtl/ieee80211_descrambler_pkg.sv | 25 ++
 rtl/ieee80211_descrambler_lfsr_step.sv | 42 ++++
 rtl/ieee80211_descrambler.sv | 95 +++++++++
 tb/tb_ieee80211_descrambler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieee80211_descrambler_pkg.sv
// Shared constants and types for the 802.11 receive descrambler (x^7 + x^4 + 1).
package ieee80211_descrambler_pkg;

    localparam int unsigned SCRAMBLER_LEN     = 7;
    localparam int unsigned TAP_HI            = 7;
    localparam int unsigned TAP_LO            = 4;
    localparam int unsigned SERVICE_SEED_BITS = 7;
    localparam int unsigned RATE_W            = 4;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } desc_state_e;

    typedef struct packed {
        logic              last;
        logic [RATE_W-1:0] user;
    } axis_side_t;

    // Feedback bit of the scrambler polynomial for a given state.
    function automatic logic lfsr_feedback(input logic [SCRAMBLER_LEN-1:0] st);
        return st[TAP_HI-1] ^ st[TAP_LO-1];
    endfunction

endpackage

// File: rtl/ieee80211_descrambler_lfsr_step.sv
// Combinational WIDTH-bit unrolled descrambler step; when seed_en is set the
// first SEED_BITS bits load the LFSR instead of being descrambled.
module ieee80211_lfsr_step
    import ieee80211_descrambler_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned SEED_BITS = SERVICE_SEED_BITS
) (
    input  logic                     seed_en,
    input  logic [SCRAMBLER_LEN-1:0] state_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic [SCRAMBLER_LEN-1:0] state_out,
    output logic [WIDTH-1:0]         data_out,
    output logic [SCRAMBLER_LEN-1:0] seed_out
);

    logic [SCRAMBLER_LEN-1:0] st;
    logic                     fb;

    always_comb begin
        st       = state_in;
        fb       = 1'b0;
        data_out = '0;
        seed_out = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            fb = lfsr_feedback(st);
            if (seed_en && (i < SEED_BITS)) begin
                data_out[i] = 1'b0;
                st          = {st[SCRAMBLER_LEN-2:0], data_in[i]};
            end else begin
                data_out[i] = data_in[i] ^ fb;
                st          = {st[SCRAMBLER_LEN-2:0], fb};
            end
            // State right after the SERVICE bits is the recovered seed.
            if (i == SEED_BITS - 1) begin
                seed_out = st;
            end
        end
        state_out = st;
    end

endmodule

// File: rtl/ieee80211_descrambler.sv
// 802.11 RX descrambler: recovers the LFSR seed from each frame's SERVICE bits
// and descrambles the rest, with one registered AXI-Stream output stage.
module ieee80211_descrambler
    import ieee80211_descrambler_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [RATE_W-1:0]        s_axis_tuser,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [RATE_W-1:0]        m_axis_tuser,
    output logic [SCRAMBLER_LEN-1:0] seed,
    output logic                     seed_valid
);

    desc_state_e              state_q;
    desc_state_e              state_d;
    logic [SCRAMBLER_LEN-1:0] lfsr_q;
    logic [SCRAMBLER_LEN-1:0] lfsr_next;
    logic [SCRAMBLER_LEN-1:0] seed_next;
    logic [WIDTH-1:0]         data_next;
    axis_side_t               side_q;
    logic                     accept_c;
    logic                     seed_word_c;

    assign s_axis_tready = m_axis_tready || !m_axis_tvalid;
    assign accept_c      = s_axis_tvalid && s_axis_tready;
    assign seed_word_c   = (state_q == ST_SEED);
    assign m_axis_tlast  = side_q.last;
    assign m_axis_tuser  = side_q.user;

    ieee80211_lfsr_step #(
        .WIDTH     (WIDTH),
        .SEED_BITS (SERVICE_SEED_BITS)
    ) u_step (
        .seed_en   (seed_word_c),
        .state_in  (lfsr_q),
        .data_in   (s_axis_tdata),
        .state_out (lfsr_next),
        .data_out  (data_next),
        .seed_out  (seed_next)
    );

    // Frame-position state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Every tlast word returns to SEED, so single-word frames work too.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = s_axis_tlast ? ST_SEED : ST_RUN;
        end
    end

    // Output stage, LFSR and seed capture all advance only on input acceptance.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            side_q        <= '0;
            lfsr_q        <= '0;
            seed          <= '0;
            seed_valid    <= 1'b0;
        end else begin
            seed_valid <= accept_c && seed_word_c;
            if (accept_c) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= data_next;
                side_q.last   <= s_axis_tlast;
                side_q.user   <= s_axis_tuser;
                lfsr_q        <= lfsr_next;
                if (seed_word_c) begin
                    seed <= seed_next;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ieee80211_descrambler.sv
// Scoreboard bench for ieee80211_descrambler: a bench-side scrambler model
// produces the input words and the expected descrambled output and seeds.
module tb_ieee80211_descrambler;

    localparam int unsigned W = 24;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [3:0]   user;
    } exp_t;

    logic         aclk = 1'b0;
    logic         areset;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [3:0]   s_axis_tuser;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [3:0]   m_axis_tuser;
    logic [6:0]   seed;
    logic         seed_valid;

    exp_t         exp_q[$];
    logic [6:0]   seed_q[$];
    int           out_cyc[$];
    logic [W-1:0] orig[16];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           seed_pulses = 0;
    bit           bp = 1'b0;
    bit           prev_stall = 1'b0;
    logic [29:0]  prev_out;
    exp_t         mon_e;

    ieee80211_descrambler #(.WIDTH(W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .seed          (seed),
        .seed_valid    (seed_valid)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop, stall stability and seed pulses.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                      32'(prev_out));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%0h exp=none", m_axis_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(m_axis_tdata), 32'(mon_e.data));
                    check("out_last", 32'(m_axis_tlast), 32'(mon_e.last));
                    check("out_user", 32'(m_axis_tuser), 32'(mon_e.user));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (seed_valid) begin
                seed_pulses++;
                if (seed_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_seed got=%0h exp=none", seed);
                end else begin
                    check("seed", 32'(seed), 32'(seed_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last, input logic [3:0] user,
                             input logic [W-1:0] expd, input logic first, input logic [6:0] eseed);
        bit   acc;
        exp_t e;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge aclk);
            acc = s_axis_tready;
            if (acc) begin
                e.data = expd;
                e.last = last;
                e.user = user;
                exp_q.push_back(e);
                if (first) seed_q.push_back(eseed);
            end
            tick();
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=stalled exp=accepted");
        end
        s_axis_tvalid = 1'b0;
    endtask

    // Scramble orig[0..n-1] from seed7 and send the first n_send words.
    task automatic send_frame(input logic [6:0] seed7, input int n, input int n_send,
                              input logic [3:0] user);
        logic [6:0]   st;
        logic [6:0]   ms;
        logic         f;
        logic [W-1:0] sd;
        logic [W-1:0] sc[16];
        st = seed7;
        ms = '0;
        orig[0][6:0] = 7'd0;
        for (int w = 0; w < n; w++) begin
            sd = '0;
            for (int i = 0; i < int'(W); i++) begin
                f     = st[6] ^ st[3];
                sd[i] = orig[w][i] ^ f;
                st    = {st[5:0], f};
                if (w == 0 && i == 6) ms = st;
            end
            sc[w] = sd;
        end
        for (int w = 0; w < n_send; w++) begin
            send_word(sc[w], w == n - 1, user, orig[w], w == 0, ms);
            if (bp) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic rand_orig(input int n);
        for (int w = 0; w < n; w++) orig[w] = W'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        tick();
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int p0;
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("rst_tdata", 32'(m_axis_tdata), 32'(0));
        check("rst_tlast", 32'(m_axis_tlast), 32'(0));
        check("rst_tuser", 32'(m_axis_tuser), 32'(0));
        check("rst_seed", 32'(seed), 32'(0));
        check("rst_seed_valid", 32'(seed_valid), 32'(0));
        check("rst_tready", 32'(s_axis_tready), 32'(1));
        @(posedge aclk);
        #1 areset = 1'b0;

        // Reference sequence: all-ones scrambler over zero data.
        for (int w = 0; w < 3; w++) orig[w] = '0;
        p0 = seed_pulses;
        send_frame(7'h7F, 3, 3, 4'h3);
        drain();
        check("ref_seed", 32'(seed), 32'h07);
        check("ref_pulses", 32'(seed_pulses - p0), 32'(1));

        // Back-to-back data recovery.
        rand_orig(10);
        out_cyc.delete();
        send_frame(7'h5D, 10, 10, 4'hA);
        drain();
        check("b2b_count", 32'(out_cyc.size()), 32'(10));
        if (out_cyc.size() >= 10) check("b2b_span", 32'(out_cyc[9] - out_cyc[0]), 32'(9));

        // Same data under backpressure and gapped input.
        bp = 1'b1;
        send_frame(7'h5D, 10, 10, 4'h6);
        drain();
        bp = 1'b0;
        tick();

        // Single-word frame followed immediately by a 2-word frame.
        p0 = seed_pulses;
        rand_orig(1);
        send_frame(7'h21, 1, 1, 4'h2);
        rand_orig(2);
        send_frame(7'h4C, 2, 2, 4'h9);
        drain();
        check("fb_pulses", 32'(seed_pulses - p0), 32'(2));

        // Reset after word 2 of a 5-word frame, then a fresh frame.
        rand_orig(5);
        send_frame(7'h33, 5, 3, 4'h5);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("mid_rst_tdata", 32'(m_axis_tdata), 32'(0));
        check("mid_rst_tlast", 32'(m_axis_tlast), 32'(0));
        check("mid_rst_tuser", 32'(m_axis_tuser), 32'(0));
        check("mid_rst_seed", 32'(seed), 32'(0));
        check("mid_rst_seed_valid", 32'(seed_valid), 32'(0));
        exp_q.delete();
        seed_q.delete();
        @(posedge aclk);
        #1 areset = 1'b0;
        p0 = seed_pulses;
        rand_orig(4);
        send_frame(7'h6E, 4, 4, 4'h5);
        drain();
        check("rst_frame_pulses", 32'(seed_pulses - p0), 32'(1));

        // tuser passthrough.
        rand_orig(3);
        send_frame(7'h12, 3, 3, 4'b1101);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
